// File: rtl/dram_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-port data RAM.
// One transfer at a time: IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> IDLE.
module dram_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int RD_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_c_req,
  input  logic       i_c_we,
  input  logic [7:0] i_c_addr,
  input  logic [7:0] i_c_wdata,
  output logic       o_c_gnt,
  output logic       o_c_rvalid,
  output logic [7:0] o_c_rdata,
  input  logic       i_d_req,
  input  logic       i_d_we,
  input  logic [7:0] i_d_addr,
  input  logic [7:0] i_d_wdata,
  output logic       o_d_gnt,
  output logic       o_d_rvalid,
  output logic [7:0] o_d_rdata,
  output logic [7:0] o_ram_addr,
  output logic [7:0] o_ram_data,
  output logic       o_ram_wren,
  input  logic [7:0] i_ram_q,
  output logic       o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t     r_state;
  logic       r_last_d;
  logic       r_win_d;
  logic       r_we;
  logic [1:0] r_wait_cnt;
  logic       r_c_gnt, r_d_gnt, r_c_rvalid, r_d_rvalid, r_ram_wren, r_busy;
  logic [7:0] r_c_rdata, r_d_rdata, r_ram_addr, r_ram_data;

  logic       w_pick_d;
  logic       w_we;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;

  // Tie-break: round-robin flips away from the last grant, fixed mode favours CPU.
  always_comb begin
    w_pick_d = i_d_req;
    if (i_c_req && i_d_req)
      w_pick_d = (ARB_MODE == 0) ? ~r_last_d : 1'b0;
    w_we    = w_pick_d ? i_d_we    : i_c_we;
    w_addr  = w_pick_d ? i_d_addr  : i_c_addr;
    w_wdata = w_pick_d ? i_d_wdata : i_c_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b1;
      r_win_d    <= 1'b0;
      r_we       <= 1'b0;
      r_wait_cnt <= 2'd0;
      r_c_gnt    <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_ram_wren <= 1'b0;
      r_busy     <= 1'b0;
      r_c_rdata  <= 8'h00;
      r_d_rdata  <= 8'h00;
      r_ram_addr <= 8'h00;
      r_ram_data <= 8'h00;
    end else begin
      r_c_gnt    <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_c_req || i_d_req) begin
            r_state    <= ISSUE;
            r_busy     <= 1'b1;
            r_win_d    <= w_pick_d;
            r_last_d   <= w_pick_d;
            r_c_gnt    <= ~w_pick_d;
            r_d_gnt    <= w_pick_d;
            r_ram_addr <= w_addr;
            r_ram_data <= w_wdata;
            r_ram_wren <= w_we;
            r_we       <= w_we;
          end
        end
        ISSUE: begin
          r_ram_wren <= 1'b0;
          if (r_we) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= WAIT;
            r_wait_cnt <= 2'(RD_LAT - 1);
          end
        end
        WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (r_win_d) begin
              r_d_rdata  <= i_ram_q;
              r_d_rvalid <= 1'b1;
            end else begin
              r_c_rdata  <= i_ram_q;
              r_c_rvalid <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_c_gnt    = r_c_gnt;
  assign o_d_gnt    = r_d_gnt;
  assign o_c_rvalid = r_c_rvalid;
  assign o_d_rvalid = r_d_rvalid;
  assign o_c_rdata  = r_c_rdata;
  assign o_d_rdata  = r_d_rdata;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_data = r_ram_data;
  assign o_ram_wren = r_ram_wren;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: three instances (RR/lat1, fixed/lat1, RR/lat2), each
// with its own RAM and a transaction-level reference model.
module tb_dram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]      c_req, c_we, d_req, d_we;
  logic [2:0][7:0] c_addr, c_wd, d_addr, d_wd;
  logic [2:0]      c_gnt, d_gnt, c_rvalid, d_rvalid, ram_wren, busy;
  logic [2:0][7:0] c_rdata, d_rdata, ram_addr, ram_data, ram_q;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dram_arbiter #(.ARB_MODE((g == 1) ? 1 : 0), .RD_LAT((g == 2) ? 2 : 1)) u_dut (
      .clk(clk), .rst(rst),
      .i_c_req(c_req[g]), .i_c_we(c_we[g]), .i_c_addr(c_addr[g]), .i_c_wdata(c_wd[g]),
      .o_c_gnt(c_gnt[g]), .o_c_rvalid(c_rvalid[g]), .o_c_rdata(c_rdata[g]),
      .i_d_req(d_req[g]), .i_d_we(d_we[g]), .i_d_addr(d_addr[g]), .i_d_wdata(d_wd[g]),
      .o_d_gnt(d_gnt[g]), .o_d_rvalid(d_rvalid[g]), .o_d_rdata(d_rdata[g]),
      .o_ram_addr(ram_addr[g]), .o_ram_data(ram_data[g]), .o_ram_wren(ram_wren[g]),
      .i_ram_q(ram_q[g]), .o_busy(busy[g])
    );
  end

  // Environment RAM: read pipeline depth equals the instance's RD_LAT.
  logic [7:0]      ram [3][256];
  logic [2:0][7:0] p1, p2;
  logic            ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int k = 0; k < 3; k++)
        for (int a = 0; a < 256; a++) ram[k][a] <= 8'(a) ^ 8'h3C;
      ram_ready <= 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (ram_wren[k]) ram[k][ram_addr[k]] <= ram_data[k];
        p1[k] <= ram[k][ram_addr[k]];
        p2[k] <= p1[k];
      end
    end
  end
  assign ram_q[0] = p1[0];
  assign ram_q[1] = p1[1];
  assign ram_q[2] = p2[2];

  function automatic int lat(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  // Reference model: one outstanding transfer per instance, described by its
  // grant cycle; every output is derived from cycle arithmetic on that record.
  int         e = 0;
  bit         tv[3], tw[3], tp[3], last_d[3];
  int         te[3];
  logic [7:0] ta[3], td[3], ea[3], ed[3], erc[3], erd[3];
  logic [7:0] mm [3][256];
  bit         mm_ready = 1'b0;

  function automatic int xfer_len(input int k);
    return tw[k] ? 2 : 2 + lat(k);
  endfunction

  task automatic mdl_reset();
    if (!mm_ready) begin
      for (int k = 0; k < 3; k++)
        for (int a = 0; a < 256; a++) mm[k][a] = 8'(a) ^ 8'h3C;
      mm_ready = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      tv[k] = 1'b0; last_d[k] = 1'b1;
      ea[k] = 8'h00; ed[k] = 8'h00; erc[k] = 8'h00; erd[k] = 8'h00;
    end
  endtask

  task automatic mdl_step();
    bit pd;
    for (int k = 0; k < 3; k++) begin
      if (tv[k]) begin
        if (tw[k] && e == te[k] + 1) mm[k][ta[k]] = td[k];
        if (!tw[k] && e == te[k] + 1 + lat(k)) begin
          if (tp[k]) erd[k] = mm[k][ta[k]];
          else       erc[k] = mm[k][ta[k]];
        end
        if (e >= te[k] + xfer_len(k)) tv[k] = 1'b0;
      end
      if (!tv[k] && (c_req[k] || d_req[k])) begin
        if (c_req[k] && d_req[k]) pd = (k == 1) ? 1'b0 : !last_d[k];
        else                      pd = d_req[k];
        tv[k] = 1'b1; te[k] = e; tp[k] = pd; last_d[k] = pd;
        tw[k] = pd ? d_we[k]   : c_we[k];
        ta[k] = pd ? d_addr[k] : c_addr[k];
        td[k] = pd ? d_wd[k]   : c_wd[k];
        ea[k] = ta[k]; ed[k] = td[k];
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) mdl_reset();
    else begin
      e++;
      mdl_step();
    end
  end

  function automatic logic [37:0] ev(input logic b, w, cg, dg, cr, dr,
                                     input logic [7:0] a, d, rc, rd);
    return {b, w, cg, dg, cr, dr, a, d, rc, rd};
  endfunction

  function automatic logic [37:0] dut_vec(input int k);
    return ev(busy[k], ram_wren[k], c_gnt[k], d_gnt[k], c_rvalid[k], d_rvalid[k],
              ram_addr[k], ram_data[k], c_rdata[k], d_rdata[k]);
  endfunction

  function automatic logic mdl_cg(input int k);
    return tv[k] && !tp[k] && e == te[k];
  endfunction

  function automatic logic mdl_dg(input int k);
    return tv[k] && tp[k] && e == te[k];
  endfunction

  function automatic logic [37:0] mdl_vec(input int k);
    logic b, rv;
    b  = tv[k] && e < te[k] + (tw[k] ? 1 : 1 + lat(k));
    rv = tv[k] && !tw[k] && e == te[k] + 1 + lat(k);
    return ev(b, tv[k] && tw[k] && e == te[k], mdl_cg(k), mdl_dg(k),
              rv && !tp[k], rv && tp[k], ea[k], ed[k], erc[k], erd[k]);
  endfunction

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_en)
      for (int k = 0; k < 3; k++) chk($sformatf("model_i%0d", k), dut_vec(k), mdl_vec(k));

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_all(input logic cr, cw, input logic [7:0] ca, cd,
                           input logic dr, dw, input logic [7:0] da, dd);
    for (int k = 0; k < 3; k++) begin
      c_req[k] = cr; c_we[k] = cw; c_addr[k] = ca; c_wd[k] = cd;
      d_req[k] = dr; d_we[k] = dw; d_addr[k] = da; d_wd[k] = dd;
    end
  endtask

  function automatic logic [7:0] rnd_addr();
    return ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
  endfunction

  typedef struct {
    logic cr, cw; logic [7:0] ca, cd;
    logic dr, dw; logic [7:0] da, dd;
    logic [37:0] exp;
  } vec_t;
  vec_t tbl [13];

  function automatic vec_t mk(input logic cr, cw, input logic [7:0] ca, cd,
                              input logic dr, dw, input logic [7:0] da, dd,
                              input logic [37:0] exp);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.exp = exp;
    return v;
  endfunction

  initial begin
    // instance 0 (round-robin, RD_LAT=1): expected outputs in the cycle after each row's inputs
    tbl[0]  = mk(1,1,8'h10,8'h5A, 0,0,8'h00,8'h00, ev(1,1,1,0,0,0,8'h10,8'h5A,8'h00,8'h00));
    tbl[1]  = mk(0,1,8'h10,8'h5A, 0,0,8'h00,8'h00, ev(0,0,0,0,0,0,8'h10,8'h5A,8'h00,8'h00));
    tbl[2]  = mk(1,0,8'h10,8'h00, 0,0,8'h00,8'h00, ev(1,0,1,0,0,0,8'h10,8'h00,8'h00,8'h00));
    tbl[3]  = mk(0,0,8'h10,8'h00, 0,0,8'h00,8'h00, ev(1,0,0,0,0,0,8'h10,8'h00,8'h00,8'h00));
    tbl[4]  = mk(0,0,8'h10,8'h00, 0,0,8'h00,8'h00, ev(0,0,0,0,1,0,8'h10,8'h00,8'h5A,8'h00));
    tbl[5]  = mk(0,0,8'h10,8'h00, 0,0,8'h00,8'h00, ev(0,0,0,0,0,0,8'h10,8'h00,8'h5A,8'h00));
    tbl[6]  = mk(1,1,8'h20,8'h11, 1,1,8'h21,8'h22, ev(1,1,0,1,0,0,8'h21,8'h22,8'h5A,8'h00));
    tbl[7]  = mk(1,1,8'h20,8'h11, 0,1,8'h21,8'h22, ev(0,0,0,0,0,0,8'h21,8'h22,8'h5A,8'h00));
    tbl[8]  = mk(1,1,8'h20,8'h11, 0,1,8'h21,8'h22, ev(1,1,1,0,0,0,8'h20,8'h11,8'h5A,8'h00));
    tbl[9]  = mk(0,1,8'h20,8'h11, 1,0,8'hFF,8'h77, ev(0,0,0,0,0,0,8'h20,8'h11,8'h5A,8'h00));
    tbl[10] = mk(0,1,8'h20,8'h11, 1,0,8'hFF,8'h77, ev(1,0,0,1,0,0,8'hFF,8'h77,8'h5A,8'h00));
    tbl[11] = mk(0,1,8'h20,8'h11, 0,0,8'hFF,8'h77, ev(1,0,0,0,0,0,8'hFF,8'h77,8'h5A,8'h00));
    tbl[12] = mk(0,1,8'h20,8'h11, 0,0,8'hFF,8'h77, ev(0,0,0,0,0,1,8'hFF,8'h77,8'h5A,8'hC3));

    drive_all(0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    repeat (2) step();
    for (int k = 0; k < 3; k++) chk($sformatf("reset_state_i%0d", k), dut_vec(k), 38'd0);

    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      drive_all(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      step();
      chk($sformatf("tbl_row%0d", i), dut_vec(0), tbl[i].exp);
    end
    drive_all(0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    step();

    // Both ports holding write requests after reset: RR alternates C,D; fixed stays on C.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    drive_all(1,1,8'h30,8'hA0, 1,1,8'h31,8'hB0);
    for (int j = 0; j < 8; j++) begin
      step();
      chk($sformatf("rr_gnt_c%0d", j), 38'({c_gnt[0], d_gnt[0]}),
          38'((j % 2 == 1) ? 2'b00 : (((j / 2) % 2 == 0) ? 2'b10 : 2'b01)));
      chk($sformatf("fp_gnt_c%0d", j), 38'({c_gnt[1], d_gnt[1]}),
          38'((j % 2 == 1) ? 2'b00 : 2'b10));
    end
    for (int k = 0; k < 3; k++) c_req[k] = 1'b0;
    step();
    chk("fp_dgnt_after_drop", 38'({c_gnt[1], d_gnt[1]}), 38'(2'b01));
    chk("rr_dgnt_after_drop", 38'({c_gnt[0], d_gnt[0]}), 38'(2'b01));
    drive_all(0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    repeat (6) step();

    // Reset during WAIT of a debug read of 8'hFF aborts it; a fresh read then completes.
    drive_all(0,0,8'h00,8'h00, 1,0,8'hFF,8'h00);
    step();
    chk("dbg_gnt", 38'(d_gnt[0]), 38'(1'b1));
    for (int k = 0; k < 3; k++) d_req[k] = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rst_async_i0", dut_vec(0), 38'd0);
    chk("rst_async_i2", dut_vec(2), 38'd0);
    step();
    chk("rst_held", dut_vec(0), 38'd0);
    rst = 1'b0;
    step();
    chk("no_rvalid_after_rst", dut_vec(0), 38'd0);
    for (int k = 0; k < 3; k++) d_req[k] = 1'b1;
    step();
    chk("ff_pass", 38'({d_gnt[0], ram_addr[0]}), 38'({1'b1, 8'hFF}));
    for (int k = 0; k < 3; k++) d_req[k] = 1'b0;
    repeat (2) step();
    chk("ff_read", 38'({d_rvalid[0], d_rdata[0]}), 38'({1'b1, 8'hC3}));
    repeat (4) step();

    // RD_LAT=2: address held three cycles; debug write raised mid-read waits for IDLE.
    drive_all(1,0,8'h42,8'h00, 0,0,8'h00,8'h00);
    step();
    chk("l2_gnt", 38'({c_gnt[2], ram_addr[2]}), 38'({1'b1, 8'h42}));
    drive_all(0,0,8'h42,8'h00, 1,1,8'h43,8'h99);
    step();
    chk("l2_hold1", 38'({busy[2], d_gnt[2], ram_addr[2]}), 38'({2'b10, 8'h42}));
    step();
    chk("l2_hold2", 38'({busy[2], d_gnt[2], ram_addr[2]}), 38'({2'b10, 8'h42}));
    step();
    chk("l2_rvalid", 38'({c_rvalid[2], busy[2], d_gnt[2], c_rdata[2]}), 38'({3'b100, 8'h7E}));
    step();
    chk("l2_dgnt", 38'({d_gnt[2], ram_wren[2], ram_addr[2], ram_data[2]}),
        38'({2'b11, 8'h43, 8'h99}));
    drive_all(0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    repeat (6) step();

    // Randomized traffic per instance, requesters following the hold-until-grant protocol.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 249) == 0) rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (!c_req[k] || mdl_cg(k)) begin
          c_req[k] = ($urandom_range(0, 9) < 6);
          c_we[k] = 1'($urandom); c_addr[k] = rnd_addr(); c_wd[k] = 8'($urandom);
        end
        if (!d_req[k] || mdl_dg(k)) begin
          d_req[k] = ($urandom_range(0, 9) < 6);
          d_we[k] = 1'($urandom); d_addr[k] = rnd_addr(); d_wd[k] = 8'($urandom);
        end
      end
    end
    rst = 1'b0;
    drive_all(0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    repeat (6) step();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter ARB_MODE, default 0; 0 = round-robin, 1 = fixed priority with CPU port winning.
REQ-002 SHALL have parameter RD_LAT, default 1; RAM read latency in cycles; legal values 1..2.
REQ-003 SHALL have clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have c_req  input  1  CPU port requests an access; held until c_gnt.
REQ-006 SHALL have c_we  input  1  CPU access is a write (1) or a read (0).
REQ-007 SHALL have c_addr  input  8  CPU data-RAM address.
REQ-008 SHALL have c_wdata  input  8  CPU write data.
REQ-009 SHALL have c_gnt  output  1  one-cycle pulse: CPU access accepted.
REQ-010 SHALL have c_rvalid  output  1  one-cycle pulse: c_rdata holds CPU read result.
REQ-011 SHALL have c_rdata  output  8  CPU read data; holds its value between reads.
REQ-012 SHALL have d_req, d_we, d_addr[7:0], d_wdata[7:0] (inputs) and d_gnt, d_rvalid, d_rdata[7:0] (outputs); the debug/display port, same meaning as the c_* signals.
REQ-013 SHALL have ram_addr  output  8  address to the single-port data RAM.
REQ-014 SHALL have ram_data  output  8  write data to the RAM.
REQ-015 SHALL have ram_wren  output  1  RAM write enable.
REQ-016 SHALL have ram_q  input  8  RAM read data, valid RD_LAT cycles after ram_addr is sampled.
REQ-017 SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL drive all outputs from registers; no combinational path from any input to any output.
REQ-019 SHALL use FSM states IDLE, ISSUE and WAIT.
REQ-020 In IDLE with no request pending: SHALL stay in IDLE with ram_wren=0, and ram_addr/ram_data SHALL hold their last values.
REQ-021 In IDLE with at least one req high at a clock edge: SHALL select one winner and enter ISSUE on that edge.
REQ-022 On entering ISSUE: SHALL load ram_addr and ram_data from the winner, set ram_wren to the winner's we, and pulse that port's gnt high for exactly the ISSUE cycle.
REQ-023 Requester SHALL hold req/we/addr/wdata stable until it sees gnt; the arbiter SHALL ignore port inputs outside the sampling edge.
REQ-024 Write transfer: SHALL spend one ISSUE cycle with ram_wren=1, then return to IDLE; ram_wren SHALL never be high outside ISSUE.
REQ-025 Read transfer: ISSUE SHALL be followed by exactly RD_LAT WAIT cycles with ram_addr held stable.
REQ-026 At the edge ending the last WAIT cycle, SHALL load ram_q into the winner's rdata, pulse its rvalid for one cycle, and return to IDLE.
REQ-027 Latency, measured from the req sampling edge N: gnt SHALL be high in cycle N..N+1; read rvalid SHALL be high in cycle N+1+RD_LAT..N+2+RD_LAT.
REQ-028 Throughput: back-to-back writes SHALL complete once every 2 cycles; back-to-back reads once every 2+RD_LAT cycles.
REQ-029 When ARB_MODE=0 and both ports request in IDLE: SHALL grant the port not granted last, and update the last-granted pointer on every grant.
REQ-030 When ARB_MODE=1 and both ports request: the CPU port SHALL always win.
REQ-031 A single requester SHALL win regardless of the last-granted pointer.
REQ-032 A req arriving while busy SHALL wait; it SHALL NOT be dropped or reordered, and SHALL be arbitrated at the first IDLE edge.
REQ-033 A port still holding req in the cycle after its gnt SHALL be treated as a new request.
REQ-034 Address arithmetic SHALL NOT exist: ram_addr SHALL equal the requester's 8-bit address unmodified, including 8'hFF.

Reset
REQ-035 While rst=1: state SHALL be IDLE; busy, ram_wren, c_gnt, d_gnt, c_rvalid, d_rvalid SHALL be 0; ram_addr, ram_data, c_rdata, d_rdata SHALL be 8'h00; the last-granted pointer SHALL be the debug port, so the CPU wins the first tie.
REQ-036 Reset during ISSUE or WAIT: SHALL abort the transfer immediately, with no rvalid and no further ram_wren for it.
REQ-037 After rst is released, the first request SHALL be sampled on the first rising edge with rst=0.

Verification
REQ-038 CPU write 8'h5A to addr 8'h10 -> c_gnt and ram_wren=1 for one cycle with ram_addr=8'h10, ram_data=8'h5A; busy for 1 cycle; no c_rvalid.
REQ-039 CPU read of addr 8'h10 after that write, RD_LAT=1 -> c_gnt at N, c_rvalid at N+2, c_rdata=8'h5A; d_rvalid stays 0.
REQ-040 ARB_MODE=0, c_req and d_req held continuously high (writes) -> grants alternate C,D,C,D, one every 2 cycles, CPU first after reset.
REQ-041 ARB_MODE=1, same stimulus -> only c_gnt pulses; d_gnt is granted in the first IDLE cycle after c_req drops.
REQ-042 rst asserted in WAIT of a debug read of addr 8'hFF -> all outputs 0 at once, no d_rvalid; next d_req is served normally, and ram_addr=8'hFF is passed through.
REQ-043 RD_LAT=2 read -> ram_addr held for 3 cycles, rvalid at N+3, and a d_req raised mid-read is granted at the first IDLE edge.
